// File: rtl/int_div_unit_if.sv
// Issue/result bundle between the EXE-stage issue logic and the iterative divider.
// Master drives the operation and the consume strobe; slave is the divider.
interface int_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            ready_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i, ready_i,
        input  busy_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i, ready_i,
        output busy_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one op in flight.
// Latency: XLEN+2 cycles from accepted start to valid_o; divide-by-zero/overflow in 1 cycle.
// Backpressure: result held in DONE until ready_i; start_i ignored while busy_o is high.
module int_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    int_div_unit_if.slave div_if
);
    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             sel_rem_q, sel_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             in_signed;
    logic             rs1_neg;
    logic             rs2_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  rs1_abs;
    logic [XLEN-1:0]  rs2_abs;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;
    logic             step_ge;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    // op_i[0] set means unsigned (DIVU/REMU); op_i[1] set selects the remainder.
    assign in_signed = ~div_if.op_i[0];
    assign rs1_neg   = in_signed & div_if.rs1_i[XLEN-1];
    assign rs2_neg   = in_signed & div_if.rs2_i[XLEN-1];
    assign rs1_abs   = rs1_neg ? -div_if.rs1_i : div_if.rs1_i;
    assign rs2_abs   = rs2_neg ? -div_if.rs2_i : div_if.rs2_i;
    assign div_zero  = (div_if.rs2_i == '0);
    assign div_ovf   = in_signed & (div_if.rs1_i == INT_MIN) & (div_if.rs2_i == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = div_if.op_i[1] ? div_if.rs1_i : '1;
        end else begin
            special_res = div_if.op_i[1] ? '0 : INT_MIN;
        end
    end

    // The shifted remainder can reach XLEN+1 bits; its top bit alone already means
    // it exceeds the divisor, otherwise the borrow of the trial subtract decides.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign step_ge = shifted[XLEN] | ~trial[XLEN];

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        if (div_if.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_if.start_i) begin
                        sel_rem_d = div_if.op_i[1];
                        rd_d      = div_if.rd_i;
                        neg_quo_d = rs1_neg ^ rs2_neg;
                        neg_rem_d = rs1_neg;
                        quo_d     = rs1_abs;
                        dvs_d     = rs2_abs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = step_ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], step_ge};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = sel_rem_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (div_if.ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign div_if.busy_o   = busy_q;
    assign div_if.valid_o  = valid_q;
    assign div_if.result_o = result_q;
    assign div_if.rd_o     = rd_q;
endmodule

// File: tb/tb_int_div_unit.sv
// Scoreboard bench for int_div_unit: randomized RV32M divide ops against a plain-arithmetic model.
// Driver pushes expectations on issue; a monitor compares result, tag and latency when valid_o is up.
module tb_int_div_unit;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          issue;
        int          lat;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    int   rdy_mode;
    exp_t exp_q[$];

    int_div_unit_if #(.XLEN(XLEN)) div_if ();

    int_div_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
        end
    endtask

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        bit special;
        sa = $signed(a);
        sb = $signed(b);
        special = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            special = 1'b1;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            special = 1'b1;
        end else if (!op[0]) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        e.res   = op[1] ? r : q;
        e.rd    = rd;
        e.issue = 0;
        e.lat   = special ? 1 : XLEN + 2;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        exp_t e;
        int n;
        n = 0;
        lat = 0;
        while (div_if.busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (div_if.busy_o) begin
            checks++;
            failures++;
            $display("FAIL issue_wait_busy actual=busy expected=idle within 200 cycles");
            return;
        end
        div_if.start_i = 1'b1;
        div_if.op_i    = op;
        div_if.rs1_i   = a;
        div_if.rs2_i   = b;
        div_if.rd_i    = rd;
        e = ref_model(op, a, b, rd);
        e.issue = cyc + 1;
        lat = e.lat;
        exp_q.push_back(e);
        @(negedge clk);
        div_if.start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Result monitor: sampled 2 time units after the negedge, once inputs have settled.
    initial begin : monitor
        logic prev_vld;
        exp_t e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_vld = 1'b0;
            end else begin
                if (div_if.valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=1 expected=0 at cycle %0d", cyc);
                    end else begin
                        e = exp_q[0];
                        if (!prev_vld) chk("latency", 32'(cyc + 1 - e.issue), 32'(e.lat));
                        chk("result", div_if.result_o, e.res);
                        chk("rd", {27'd0, div_if.rd_o}, {27'd0, e.rd});
                        if (div_if.ready_i && !div_if.flush_i) void'(exp_q.pop_front());
                    end
                end
                prev_vld = div_if.valid_o;
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(negedge clk);
            if (rdy_mode == 1) div_if.ready_i = ($urandom_range(0, 2) != 0);
            else if (rdy_mode == 0) div_if.ready_i = 1'b1;
        end
    end

    initial begin : main
        int lat;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rdy_mode = 0;
        reset_n  = 1'b0;
        div_if.start_i = 1'b0;
        div_if.op_i    = 2'b00;
        div_if.rs1_i   = '0;
        div_if.rs2_i   = '0;
        div_if.rd_i    = '0;
        div_if.flush_i = 1'b0;
        div_if.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, div_if.busy_o}, 32'd0);
        chk("reset_valid", {31'd0, div_if.valid_o}, 32'd0);
        chk("reset_result", div_if.result_o, 32'd0);
        chk("reset_rd", {27'd0, div_if.rd_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: plain, signed, divide-by-zero and overflow cases.
        issue(2'b01, 32'd100, 32'd7, 5'd3, lat);
        issue(2'b11, 32'd100, 32'd7, 5'd4, lat);
        issue(2'b00, -32'sd7, 32'd2, 5'd5, lat);
        issue(2'b10, -32'sd7, 32'd2, 5'd6, lat);
        issue(2'b00, 32'd7, -32'sd2, 5'd7, lat);
        issue(2'b10, 32'd7, -32'sd2, 5'd8, lat);
        issue(2'b00, 32'd5, 32'd0, 5'd9, lat);
        issue(2'b11, 32'd5, 32'd0, 5'd10, lat);
        issue(2'b01, 32'd0, 32'd0, 5'd11, lat);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat);
        drain();

        // Backpressure: hold DONE, try a new start, release.
        rdy_mode = 2;
        div_if.ready_i = 1'b0;
        issue(2'b01, 32'd1000, 32'd10, 5'd15, lat);
        for (int n = 0; n < 100 && !div_if.valid_o; n++) @(negedge clk);
        chk("bp_valid_up", {31'd0, div_if.valid_o}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            div_if.start_i = (k == 1);
            div_if.op_i    = 2'b01;
            div_if.rs1_i   = 32'd77;
            div_if.rs2_i   = 32'd11;
            div_if.rd_i    = 5'd30;
            @(negedge clk);
        end
        div_if.start_i = 1'b0;
        div_if.ready_i = 1'b1;
        @(negedge clk);
        div_if.ready_i = 1'b0;
        chk("bp_idle_busy", {31'd0, div_if.busy_o}, 32'd0);
        chk("bp_idle_valid", {31'd0, div_if.valid_o}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_start_ignored", {31'd0, div_if.busy_o}, 32'd0);
        rdy_mode = 0;

        // Flush at CALC step 10, then a fresh op.
        issue(2'b01, 32'd12345, 32'd17, 5'd16, lat);
        repeat (10) @(negedge clk);
        div_if.flush_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        div_if.flush_i = 1'b0;
        chk("flush_busy", {31'd0, div_if.busy_o}, 32'd0);
        chk("flush_valid", {31'd0, div_if.valid_o}, 32'd0);
        repeat (40) @(negedge clk);
        issue(2'b01, 32'd9, 32'd3, 5'd17, lat);
        drain();

        // Async reset in the middle of CALC.
        issue(2'b01, 32'd500, 32'd3, 5'd18, lat);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_busy", {31'd0, div_if.busy_o}, 32'd0);
        chk("arst_valid", {31'd0, div_if.valid_o}, 32'd0);
        chk("arst_result", div_if.result_o, 32'd0);
        chk("arst_rd", {27'd0, div_if.rd_o}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized ops with random backpressure and occasional flushes.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin
                    a = 32'($urandom_range(0, 200)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
                    b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
                end
                4: a = 32'($urandom_range(0, 1000));
                default: b = 32'($urandom_range(1, 255));
            endcase
            issue(op, a, b, 5'($urandom_range(1, 31)), lat);
            if (lat == XLEN + 2 && $urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                div_if.flush_i = 1'b1;
                exp_q.delete();
                @(negedge clk);
                div_if.flush_i = 1'b0;
                chk("rand_flush_busy", {31'd0, div_if.busy_o}, 32'd0);
            end
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
